encryptor_decryptor: RTL and testbench
======================================

Name: encryptor_decryptor

Overview:
Streaming byte cipher with a repeating key, usable as the encryptor or the decryptor of a fixed-length message. Each input byte is combined modulo 256 with a key byte, and the key repeats every SEC_LEN bytes. Encrypt mode adds the key byte; decrypt mode subtracts it, so a decryptor restores an encryptor's plaintext when both use the same key. The block sits between a byte source and a byte sink, with valid/ready on both sides.

Parameters:
MSG_LEN, 20, bytes per message; out_last marks byte MSG_LEN-1 (MSG_LEN >= 1)
SEC_LEN, 3, key length in bytes (SEC_LEN >= 1)
KEY, {8'h07,8'h05,8'h03}, reset key, SEC_LEN*8 bits; key byte j = KEY[8j+7:8j]

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
mode  in  1  0 = encrypt (add), 1 = decrypt (subtract)
key_we  in  1  key write strobe
key_in  in  SEC_LEN*8  new key; byte j = key_in[8j+7:8j]
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  block accepts in_data this cycle
out_valid  out  1  output byte valid
out_data  out  8  processed byte
out_last  out  1  out_data is the last byte of a message
out_ready  in  1  sink accepts output this cycle

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_last=0.
  - byte_idx=0, key_idx=0.
  - Key register loads KEY; latched mode = encrypt.
- in_ready = !key_we && (!out_valid || out_ready). The output is a single register stage.
- Input transfer happens when in_valid && in_ready.
- On a transfer, at the next edge:
  - out_data = in_data + key[key_idx] (mod 256) when encrypting, or in_data - key[key_idx] (mod 256) when decrypting.
  - out_valid=1; out_last = (byte_idx == MSG_LEN-1).
- Latency is 1 cycle, with one byte per cycle throughput when out_ready stays high.
- Output transfer happens when out_valid && out_ready. If there is no new input transfer in that cycle, out_valid and out_last clear.
- While out_valid && !out_ready: out_data and out_last hold stable and in_ready=0.
- Counters on each input transfer:
  - key_idx increments and wraps from SEC_LEN-1 to 0.
  - byte_idx increments. After byte MSG_LEN-1, both byte_idx and key_idx return to 0, so every message starts at key byte 0 regardless of MSG_LEN mod SEC_LEN.
- Mode latching:
  - mode is sampled on the transfer with byte_idx==0 and held for the whole message.
  - Changes to mode mid-message are ignored until the next message.
- Key write:
  - key_we=1 with byte_idx==0 loads key_in at the next edge.
  - key_we while byte_idx!=0 is ignored.
  - in_ready is forced 0 while key_we=1, so a key write and a data transfer never coincide.
  - A byte already in the output register is unaffected by a key write.
- Arithmetic is 8-bit wrap, no saturation; all 256 byte values are legal in both directions.
- Reset mid-message aborts the message: the pending output is dropped, the indexes return to 0 and the key returns to KEY.

Test Plan:
- Encrypt with reset key 03/05/07, input "AABBCCDDEEAABBCCDDEE" -> out_data = 68,70,73,69,72,74,71,73,76,72,70,72,69,71,74,70,73,75,72,74; out_last=1 only on the 20th byte.
- Decrypt those 20 values with the same key -> "AABBCCDDEEAABBCCDDEE"; repeated letters differ in ciphertext, plaintext round-trips exactly.
- Load key FF/FF/FF at byte_idx 0, encrypt 0x02 -> 0x01; decrypt 0x01 -> 0x02 (mod-256 wrap).
- Hold out_ready=0 for 3 cycles after the first byte -> in_ready=0, out_data/out_last stable; release -> stream continues with no loss or duplication.
- Toggle mode and assert key_we at byte 5 -> bytes 5..19 still use the original mode and key; the next message uses the new mode.
- Assert rst after 7 bytes -> outputs 0 immediately; the next byte is treated as byte 0 with key byte 0x03.

Source files
------------

// File: rtl/encryptor_decryptor.sv
// Purpose: streaming repeating-key byte cipher; encrypt adds key byte, decrypt subtracts (mod 256).
// Latency: 1 cycle from input transfer to out_valid; one byte per cycle while out_ready is high.
// Backpressure: single output register; in_ready drops while out_valid && !out_ready or key_we.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   mode                0 = encrypt, 1 = decrypt; latched on the first byte of each message
//   key_we, key_in      key load, honoured only between messages (byte index 0)
//   in_valid/in_ready   input byte handshake, in_data carries the byte
//   out_valid/out_ready output byte handshake, out_data/out_last carry the result
module encryptor_decryptor #(
  parameter int                   MSG_LEN = 20,
  parameter int                   SEC_LEN = 3,
  parameter logic [SEC_LEN*8-1:0] KEY     = {8'h07, 8'h05, 8'h03}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 key_we,
  input  logic [SEC_LEN*8-1:0] key_in,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_last,
  input  logic                 out_ready
);

  // +1 keeps the widths at least one bit when MSG_LEN or SEC_LEN is 1
  localparam int BW = $clog2(MSG_LEN + 1);
  localparam int KW = $clog2(SEC_LEN + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(MSG_LEN - 1);
  localparam logic [KW-1:0] LAST_KEY  = KW'(SEC_LEN - 1);

  logic [SEC_LEN*8-1:0] r_key;
  logic [BW-1:0]        r_byte_idx;
  logic [KW-1:0]        r_key_idx;
  logic                 r_mode;
  logic                 r_out_valid;
  logic [7:0]           r_out_data;
  logic                 r_out_last;

  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_first;
  logic       w_last;
  logic       w_mode;
  logic [7:0] w_key_byte;
  logic [7:0] w_result;

  assign in_ready   = !key_we && (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_first    = (r_byte_idx == '0);
  assign w_last     = (r_byte_idx == LAST_BYTE);

  // The first byte of a message uses the live mode pin; later bytes use the latched copy
  assign w_mode     = w_first ? mode : r_mode;
  assign w_key_byte = r_key[{r_key_idx, 3'b000} +: 8];
  assign w_result   = w_mode ? (in_data - w_key_byte) : (in_data + w_key_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key       <= KEY;
      r_byte_idx  <= '0;
      r_key_idx   <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_last  <= w_last;
        if (w_first) begin
          r_mode <= mode;
        end
        // Every message restarts at key byte 0, independent of MSG_LEN mod SEC_LEN
        if (w_last) begin
          r_byte_idx <= '0;
          r_key_idx  <= '0;
        end else begin
          r_byte_idx <= r_byte_idx + 1'b1;
          r_key_idx  <= (r_key_idx == LAST_KEY) ? '0 : r_key_idx + 1'b1;
        end
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      // key_we blocks in_ready, so a key load never races a data transfer
      if (key_we && w_first) begin
        r_key <= key_in;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_encryptor_decryptor.sv
module tb_encryptor_decryptor;

  localparam int          MSG_LEN = 20;
  localparam int          SEC_LEN = 3;
  localparam logic [23:0] KEY     = {8'h07, 8'h05, 8'h03};

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        key_we;
  logic [23:0] key_in;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;

  encryptor_decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN), .KEY(KEY)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .key_we    (key_we),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries are {data, last}; cap collects bytes the sink accepted
  logic [8:0] sbq[$];
  logic [7:0] cap[$];

  // Reference model state: position within message, latched mode, key
  int          m_pos  = 0;
  logic        m_mode = 1'b0;
  logic [23:0] m_key  = KEY;

  int rdy_mode = 0;  // 0: sink always ready, 1: random, 2: stalled

  logic [7:0] msg[MSG_LEN];
  logic [7:0] ct[MSG_LEN] = '{68, 70, 73, 69, 72, 74, 71, 73, 76, 72,
                              70, 72, 69, 71, 74, 70, 73, 75, 72, 74};
  string      pt = "AABBCCDDEEAABBCCDDEE";

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] d, input logic m);
    logic [7:0] k;
    logic [7:0] r;
    if (m_pos == 0) m_mode = m;
    k = m_key[8*(m_pos % SEC_LEN) +: 8];
    r = m_mode ? d - k : d + k;
    sbq.push_back({r, (m_pos == MSG_LEN - 1)});
    m_pos = (m_pos + 1) % MSG_LEN;
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted
  task automatic send(input logic [7:0] d, input logic m);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    forever begin
      #1;
      if (in_ready) begin
        model_push(d, m);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      t++;
      if (t > 1000) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input logic m);
    for (int i = 0; i < MSG_LEN; i++) send(msg[i], m);
  endtask

  task automatic key_write(input logic [23:0] k);
    key_we = 1'b1;
    key_in = k;
    #1;
    check("in_ready_during_key_we", in_ready, 0);
    if (m_pos == 0) m_key = k;
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    sbq.delete();
    m_pos  = 0;
    m_mode = 1'b0;
    m_key  = KEY;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain_pending", sbq.size(), 0);
  endtask

  // Sink readiness, updated on the falling edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: samples between the falling edge and the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          check("out_data", out_data, sbq[0][8:1]);
          check("out_last", out_last, sbq[0][0]);
          if (out_ready) begin
            void'(sbq.pop_front());
            cap.push_back(out_data);
          end else begin
            check("stall_in_ready", in_ready, 0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    rst      = 1'b0;
    mode     = 1'b0;
    key_we   = 1'b0;
    key_in   = '0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    do_reset();

    // Known-answer encrypt with the reset key
    for (int i = 0; i < MSG_LEN; i++) msg[i] = pt[i];
    cap.delete();
    send_msg(1'b0);
    drain();
    for (int i = 0; i < MSG_LEN; i++) check("kat_encrypt", cap[i], ct[i]);

    // Decrypt the ciphertext back to the plaintext
    for (int i = 0; i < MSG_LEN; i++) msg[i] = ct[i];
    cap.delete();
    send_msg(1'b1);
    drain();
    for (int i = 0; i < MSG_LEN; i++) check("kat_decrypt", cap[i], pt[i]);

    // Key FF/FF/FF: wrap-around in both directions
    key_write(24'hFFFFFF);
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'($urandom);
    msg[0] = 8'h02;
    cap.delete();
    send_msg(1'b0);
    drain();
    check("wrap_encrypt", cap[0], 8'h01);
    msg[0] = 8'h01;
    cap.delete();
    send_msg(1'b1);
    drain();
    check("wrap_decrypt", cap[0], 8'h02);

    // Sink stalls for three cycles after the first byte
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'($urandom);
    rdy_mode = 2;
    send(msg[0], 1'b0);
    fork
      begin
        repeat (3) @(negedge clk);
        rdy_mode = 0;
      end
    join_none
    for (int i = 1; i < MSG_LEN; i++) send(msg[i], 1'b0);
    drain();

    // Mode toggle and key write at byte 5 are ignored until the next message
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) send(msg[i], 1'b0);
    key_write(24'($urandom));
    for (int i = 5; i < MSG_LEN; i++) send(msg[i], 1'b1);
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'($urandom);
    send_msg(1'b1);
    drain();

    // Reset after 7 bytes; next byte is byte 0 under the reset key
    rdy_mode = 1;
    for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0);
    do_reset();
    cap.delete();
    rdy_mode = 0;
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'($urandom);
    msg[0] = 8'h10;
    send_msg(1'b0);
    drain();
    check("post_reset_first_byte", cap[0], 8'h13);

    // Random messages with random modes, keys and sink backpressure
    rdy_mode = 1;
    for (int n = 0; n < 8; n++) begin
      if ($urandom % 2 == 1) key_write(24'($urandom));
      m = 1'($urandom % 2);
      for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'($urandom);
      send_msg(m);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
